axi_wr_arbiter: RTL

//  Round-robin arbiter that shares one AXI write port (AW/W/B) between NUM_REQ requesters.

---
 rtl/axi_wr_arbiter_if.sv | 64 ++++++
 rtl/axi_wr_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/axi_wr_arbiter_if.sv
// ============================================================================
// Module   : axi_wr_arbiter_if
// Purpose  : Requester-side and AXI-side write channels of the write arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface axi_wr_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 16,
  parameter int ADD_WIDTH  = 8,
  parameter int ID_WIDTH   = 8
);
  localparam int STRB_W = DATA_WIDTH / 8;

  // requester side, packed per requester
  logic [NUM_REQ-1:0]            s_awvalid;
  logic [NUM_REQ-1:0]            s_awready;
  logic [NUM_REQ*ADD_WIDTH-1:0]  s_awaddr;
  logic [NUM_REQ*8-1:0]          s_awlen;
  logic [NUM_REQ*3-1:0]          s_awsize;
  logic [NUM_REQ-1:0]            s_wvalid;
  logic [NUM_REQ-1:0]            s_wready;
  logic [NUM_REQ*DATA_WIDTH-1:0] s_wdata;
  logic [NUM_REQ*STRB_W-1:0]     s_wstrb;
  logic [NUM_REQ-1:0]            s_wlast;
  logic [NUM_REQ-1:0]            s_bvalid;
  logic [NUM_REQ-1:0]            s_bready;

  // shared AXI write port
  logic                  awvalid;
  logic                  awready;
  logic [ADD_WIDTH-1:0]  awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [ID_WIDTH-1:0]   awid;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_W-1:0]     wstrb;
  logic                  wlast;
  logic [ID_WIDTH-1:0]   wid;
  logic                  bvalid;
  logic                  bready;
  logic [ID_WIDTH-1:0]   bid;

  // arbiter view
  modport master (
    input  s_awvalid, s_awaddr, s_awlen, s_awsize, s_wvalid, s_wdata, s_wstrb, s_wlast, s_bready,
    output s_awready, s_wready, s_bvalid,
    output awvalid, awaddr, awlen, awsize, awid, wvalid, wdata, wstrb, wlast, wid, bready,
    input  awready, wready, bvalid, bid
  );

  // requesters plus downstream slave view
  modport slave (
    output s_awvalid, s_awaddr, s_awlen, s_awsize, s_wvalid, s_wdata, s_wstrb, s_wlast, s_bready,
    input  s_awready, s_wready, s_bvalid,
    input  awvalid, awaddr, awlen, awsize, awid, wvalid, wdata, wstrb, wlast, wid, bready,
    output awready, wready, bvalid, bid
  );
endinterface

`default_nettype wire

// File: rtl/axi_wr_arbiter.sv
// ============================================================================
// Module   : axi_wr_arbiter
// Purpose  : Round-robin arbiter sharing one AXI write port between requesters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module axi_wr_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 16,
  parameter int ADD_WIDTH  = 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                aclk,
  input  logic                areset,
  axi_wr_arbiter_if.master    bus,
  output logic [1:0]          err
);
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int STRB_W = DATA_WIDTH / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [7:0]       r_beat_cnt;
  logic [1:0]       r_err;

  logic             w_any;
  logic [IDX_W-1:0] w_pick;
  logic [IDX_W-1:0] w_idx_next;
  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_wlast;
  logic             w_bid_ok;
  logic [IDX_W-1:0] w_bid_idx;

  // Scan from the highest offset down so the requester closest to r_rr_ptr wins.
  always_comb begin
    int j;
    w_any  = 1'b0;
    w_pick = r_rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(r_rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (bus.s_awvalid[j]) begin
        w_any  = 1'b1;
        w_pick = IDX_W'(j);
      end
    end
  end

  assign w_idx_next = (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
  assign w_wlast    = (r_beat_cnt == 8'd0);
  assign w_aw_hs    = (r_state == ST_ADDR) && bus.awready;
  assign w_w_hs     = (r_state == ST_DATA) && bus.s_wvalid[r_idx] && bus.wready;

  // State register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_any)             w_next_state = ST_ADDR;
      ST_ADDR: if (w_aw_hs)           w_next_state = ST_DATA;
      ST_DATA: if (w_w_hs && w_wlast) w_next_state = ST_IDLE;
      default:                        w_next_state = ST_IDLE;
    endcase
  end

  // Grant, beat counter, round-robin pointer and sticky errors
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_idx      <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= 8'd0;
      r_err      <= 2'b00;
    end else begin
      if (r_state == ST_IDLE && w_any) r_idx <= w_pick;
      if (w_aw_hs) r_beat_cnt <= bus.s_awlen[r_idx*8 +: 8];
      if (w_w_hs) begin
        if (!w_wlast) r_beat_cnt <= r_beat_cnt - 8'd1;
        if (bus.s_wlast[r_idx] != w_wlast) r_err[0] <= 1'b1;
        if (w_wlast) r_rr_ptr <= w_idx_next;
      end
      if (bus.bvalid && !w_bid_ok) r_err[1] <= 1'b1;
    end
  end

  // AW/W outputs: payload always follows the granted slice, valids gated by state
  always_comb begin
    bus.awvalid = (r_state == ST_ADDR);
    bus.awaddr  = bus.s_awaddr[r_idx*ADD_WIDTH +: ADD_WIDTH];
    bus.awlen   = bus.s_awlen[r_idx*8 +: 8];
    bus.awsize  = bus.s_awsize[r_idx*3 +: 3];
    bus.awid    = ID_WIDTH'(r_idx);
    bus.wid     = ID_WIDTH'(r_idx);
    bus.wvalid  = (r_state == ST_DATA) && bus.s_wvalid[r_idx];
    bus.wdata   = bus.s_wdata[r_idx*DATA_WIDTH +: DATA_WIDTH];
    bus.wstrb   = bus.s_wstrb[r_idx*STRB_W +: STRB_W];
    bus.wlast   = (r_state == ST_DATA) && w_wlast;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.s_awready[i] = (r_state == ST_ADDR) && (r_idx == IDX_W'(i)) && bus.awready;
      bus.s_wready[i]  = (r_state == ST_DATA) && (r_idx == IDX_W'(i)) && bus.wready;
    end
  end

  // B routing ignores the FSM; out-of-range ids are absorbed so the slave never stalls.
  assign w_bid_ok  = ({1'b0, bus.bid} < (ID_WIDTH + 1)'(NUM_REQ));
  assign w_bid_idx = bus.bid[IDX_W-1:0];

  always_comb begin
    bus.bready = !areset && (w_bid_ok ? bus.s_bready[w_bid_idx] : 1'b1);
    for (int i = 0; i < NUM_REQ; i++)
      bus.s_bvalid[i] = !areset && bus.bvalid && w_bid_ok && (w_bid_idx == IDX_W'(i));
  end

  assign err = r_err;

endmodule

`default_nettype wire
